// File: rtl/diff_codec.sv
// Differential symbol encoder/decoder on AXI-Stream with a 2-entry output buffer.
// Optional Gray-coded symbol mapping is enabled by defining DIFF_CODEC_GRAY_EN.
module diff_codec #(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int BITS_PER_SYM           = 1,
    parameter int REF_INIT               = 0,
    parameter int RESET_ON_LAST          = 1
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_aresetn,
    input  logic                                  mode,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic [31:0]                           sym_count,
    output logic [15:0]                           frame_count
);

    localparam int K = BITS_PER_SYM;
    localparam logic [K-1:0] REF_SYM = REF_INIT[K-1:0];

    logic [K-1:0] ref_sym;
    logic [K-1:0] head_y;
    logic [K-1:0] skid_y;
    logic         head_last;
    logic         skid_last;
    logic [1:0]   count;

    logic         in_hs;
    logic         pop;
    logic [K-1:0] x_bin;
    logic [K-1:0] y_bin;
    logic [K-1:0] y_sym;
    logic [K-1:0] ref_next;

    logic unused_in;
    assign unused_in = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:K]};

`ifdef DIFF_CODEC_GRAY_EN
    function automatic logic [K-1:0] gray_to_bin(input logic [K-1:0] g);
        logic [K-1:0] b;
        b[K-1] = g[K-1];
        for (int i = K - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [K-1:0] bin_to_gray(input logic [K-1:0] b);
        return b ^ (b >> 1);
    endfunction
`endif

    // ref is always held in binary; Gray mapping only touches the symbol edges
    always_comb begin
        x_bin    = s00_axis_tdata[K-1:0];
`ifdef DIFF_CODEC_GRAY_EN
        x_bin    = gray_to_bin(s00_axis_tdata[K-1:0]);
`endif
        y_bin    = x_bin - ref_sym;
        ref_next = x_bin;
        if (mode) begin
            y_bin    = ref_sym + x_bin;
            ref_next = y_bin;
        end
        y_sym    = y_bin;
`ifdef DIFF_CODEC_GRAY_EN
        y_sym    = bin_to_gray(y_bin);
`endif
    end

    assign s00_axis_tready = s00_axis_aresetn & (count != 2'd2);
    assign in_hs           = s00_axis_tvalid & s00_axis_tready;
    assign pop             = (count != 2'd0) & m00_axis_tready;

    assign m00_axis_tvalid = (count != 2'd0);
    assign m00_axis_tlast  = head_last;
    assign m00_axis_tdata  = {{(C_M00_AXIS_TDATA_WIDTH-K){1'b0}}, head_y};
    assign m00_axis_tstrb  = '1;

    always_ff @(posedge s00_axis_aclk) begin
        if (!s00_axis_aresetn) begin
            ref_sym     <= REF_SYM;
            head_y      <= '0;
            head_last   <= 1'b0;
            skid_y      <= '0;
            skid_last   <= 1'b0;
            count       <= 2'd0;
            sym_count   <= 32'd0;
            frame_count <= 16'd0;
        end else begin
            if (in_hs) begin
                sym_count <= sym_count + 32'd1;
                if (s00_axis_tlast) begin
                    frame_count <= frame_count + 16'd1;
                end
                if (s00_axis_tlast && (RESET_ON_LAST != 0)) begin
                    ref_sym <= REF_SYM;
                end else begin
                    ref_sym <= ref_next;
                end
            end

            // head is the visible output entry, skid holds the second entry
            case (count)
                2'd0: begin
                    if (in_hs) begin
                        head_y    <= y_sym;
                        head_last <= s00_axis_tlast;
                        count     <= 2'd1;
                    end
                end
                2'd1: begin
                    if (in_hs && pop) begin
                        head_y    <= y_sym;
                        head_last <= s00_axis_tlast;
                    end else if (in_hs) begin
                        skid_y    <= y_sym;
                        skid_last <= s00_axis_tlast;
                        count     <= 2'd2;
                    end else if (pop) begin
                        count     <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_y    <= skid_y;
                        head_last <= skid_last;
                        count     <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule
